fir_out_requant: RTL

FIR_OUT_REQUANT -- requirements
Module: fir_out_requant

---
 rtl/fir_pkg.sv | 12 +
 rtl/fir_out_fifo.sv | 105 ++++++++++
 rtl/fir_out_requant.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FIR constants: word widths and coefficient scale used by the FIR stage
// and by the output requantiser.
package fir_pkg;

  // FIR accumulator output width
  localparam int FIR_N3 = 32;
  // Output sample width
  localparam int FIR_N2 = 16;
  // Fractional bits of the Q7 coefficients
  localparam int FIR_COEF_FRAC = 7;

endpackage

// File: rtl/fir_out_fifo.sv
// Output FIFO of the requantiser: registered head word and valid flag,
// wrapping read/write pointers, push into a full FIFO accepted only with a pop.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int W     = FIR_N2,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [W-1:0]  out_data,
  output logic          out_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [LW-1:0] count_r;
  logic          valid_r;
  logic [W-1:0]  head_r;

  logic          pop_s;
  logic          push_s;
  logic [PW-1:0] rd_next_s;
  logic [PW-1:0] wr_next_s;
  logic [LW-1:0] count_next_s;
  logic [W-1:0]  head_next_s;

  // Pointer increment with explicit wrap at DEPTH-1
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Next-state decode: accepted push/pop, pointers, occupancy and next head word
  always_comb begin
    full         = (count_r == LW'(DEPTH));
    pop_s        = pop && valid_r;
    push_s       = push && (!full || pop_s);
    rd_next_s    = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
    wr_next_s    = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + LW'(1);
      2'b01:   count_next_s = count_r - LW'(1);
      default: count_next_s = count_r;
    endcase
    // A push lands at the head when the FIFO is empty once this edge's pop is done
    if (count_next_s == {LW{1'b0}}) begin
      head_next_s = {W{1'b0}};
    end else if (push_s && (count_r == (pop_s ? LW'(1) : LW'(0)))) begin
      head_next_s = push_data;
    end else begin
      head_next_s = mem[rd_next_s];
    end
  end

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push_s && !clr) begin
      mem[wr_ptr_r] <= push_data;
    end
  end

  // Control state: pointers, occupancy, valid flag and registered head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {LW{1'b0}};
      valid_r  <= 1'b0;
      head_r   <= {W{1'b0}};
    end else if (clr) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {LW{1'b0}};
      valid_r  <= 1'b0;
      head_r   <= {W{1'b0}};
    end else begin
      rd_ptr_r <= rd_next_s;
      wr_ptr_r <= wr_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != {LW{1'b0}});
      head_r   <= head_next_s;
    end
  end

  assign empty     = !valid_r;
  assign level     = count_r;
  assign out_data  = head_r;
  assign out_valid = valid_r;

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantiser: decimate, round (half toward +inf), shift out the
// coefficient scale, saturate to N2 bits, one pipeline stage, then output FIFO.
// Optional feature macro: FIR_REQUANT_SATCNT_EN adds the 16-bit sat_count output.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int N3    = FIR_N3,
  parameter int N2    = FIR_N2,
  parameter int SHIFT = FIR_COEF_FRAC,
  parameter int DECIM = 1,
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    ENABLE,
  input  logic signed [N3-1:0]    filter_data,
  input  logic                    CLR,
  output logic signed [N2-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
`ifdef FIR_REQUANT_SATCNT_EN
  , output logic [15:0]           sat_count
`endif
);

  localparam int SW = N3 + 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [SW-1:0] ROUND_BIAS = SW'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [SW-1:0] SAT_MAX    = SW'((64'sd1 <<< (N2 - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_MIN    = SW'(-(64'sd1 <<< (N2 - 1)));

  logic signed [SW-1:0] ext_s;
  logic signed [SW-1:0] sum_s;
  logic signed [SW-1:0] shr_s;
  logic [N2-1:0]        req_s;
  logic                 sat_s;
  logic                 keep_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;

  logic [DW-1:0]        dcnt_r;
  logic                 stage_valid_r;
  logic [N2-1:0]        stage_data_r;
  logic                 overflow_r;

  // Requantise: one extra bit of headroom so the rounding bias cannot wrap
  always_comb begin
    ext_s = {filter_data[N3-1], filter_data};
    sum_s = ext_s + ROUND_BIAS;
    shr_s = sum_s >>> SHIFT;
    if (shr_s > SAT_MAX) begin
      req_s = SAT_MAX[N2-1:0];
      sat_s = 1'b1;
    end else if (shr_s < SAT_MIN) begin
      req_s = SAT_MIN[N2-1:0];
      sat_s = 1'b1;
    end else begin
      req_s = shr_s[N2-1:0];
      sat_s = 1'b0;
    end
    keep_s = ENABLE && (dcnt_r == {DW{1'b0}});
    pop_s  = out_ready && !empty_s;
  end

  // Decimation counter: advances on every accepted sample, wraps at DECIM-1
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dcnt_r <= {DW{1'b0}};
    end else if (CLR) begin
      dcnt_r <= {DW{1'b0}};
    end else if (ENABLE) begin
      dcnt_r <= (dcnt_r == DW'(DECIM - 1)) ? {DW{1'b0}} : dcnt_r + DW'(1);
    end else begin
      dcnt_r <= dcnt_r;
    end
  end

  // Pipeline stage holding the requantised kept sample for one cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stage_valid_r <= 1'b0;
      stage_data_r  <= {N2{1'b0}};
    end else if (CLR) begin
      stage_valid_r <= 1'b0;
      stage_data_r  <= {N2{1'b0}};
    end else begin
      stage_valid_r <= keep_s;
      stage_data_r  <= keep_s ? req_s : stage_data_r;
    end
  end

  // Sticky overflow: a staged sample meets a full FIFO with no pop
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overflow_r <= 1'b0;
    end else if (CLR) begin
      overflow_r <= 1'b0;
    end else if (stage_valid_r && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;

`ifdef FIR_REQUANT_SATCNT_EN
  logic [15:0] sat_count_r;

  // Count saturated kept samples, holding at all-ones
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sat_count_r <= 16'h0000;
    end else if (CLR) begin
      sat_count_r <= 16'h0000;
    end else if (keep_s && sat_s && (sat_count_r != 16'hFFFF)) begin
      sat_count_r <= sat_count_r + 16'h0001;
    end else begin
      sat_count_r <= sat_count_r;
    end
  end

  assign sat_count = sat_count_r;
`endif

  fir_out_fifo #(
    .W     (N2),
    .DEPTH (DEPTH),
    .LW    ($clog2(DEPTH) + 1)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr       (CLR),
    .push      (stage_valid_r),
    .push_data (stage_data_r),
    .pop       (out_ready),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

endmodule
